ysyx_23060025_icache_axi_rd: RTL

Read-only AXI4 burst master directly downstream of the instruction cache. It turns the cache's line-refill request (paddr/psel/arlen/arsize) into one AR transaction and hands the R beats back as out_rvalid/out_rlast/out_rdata. It owns the beat counting, ID filtering and response-error capture, so the cache sees a clean, single-cycle-per-beat stream.

---
 rtl/ysyx_23060025_icache_axi_rd_pkg.sv | 15 +
 rtl/ysyx_23060025_icache_axi_rd_if.sv | 55 +++++
 rtl/ysyx_23060025_icache_axi_rd.sv | 103 ++++++++++
 3 files changed

// File: rtl/ysyx_23060025_icache_axi_rd_pkg.sv
// rtl/ysyx_23060025_icache_axi_rd_pkg.sv - shared AXI constants and FSM state encoding for the icache read master
package ysyx_23060025_icache_axi_rd_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [2:0] AXI_ADDR_SIZE_4 = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADDR    = 2'd1,
    ST_DATA    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/ysyx_23060025_icache_axi_rd_if.sv
// rtl/ysyx_23060025_icache_axi_rd_if.sv - icache refill request/beat signals plus AXI AR/R channels
interface ysyx_23060025_icache_axi_rd_if #(
  parameter int ID_W       = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  // icache side
  logic [ADDR_WIDTH-1:0] in_paddr;
  logic                  in_psel;
  logic [7:0]            in_arlen;
  logic [2:0]            in_arsize;
  logic                  out_rvalid;
  logic                  out_rlast;
  logic [DATA_WIDTH-1:0] out_rdata;
  logic                  out_rerr;

  // AXI AR channel
  logic                  m_arvalid;
  logic                  m_arready;
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic [ID_W-1:0]       m_arid;
  logic [7:0]            m_arlen;
  logic [2:0]            m_arsize;
  logic [1:0]            m_arburst;

  // AXI R channel
  logic                  m_rvalid;
  logic                  m_rready;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic [1:0]            m_rresp;
  logic                  m_rlast;
  logic [ID_W-1:0]       m_rid;

  // the read master itself
  modport master (
    input  in_paddr, in_psel, in_arlen, in_arsize,
    output out_rvalid, out_rlast, out_rdata, out_rerr,
    output m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst,
    input  m_arready,
    input  m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
    output m_rready
  );

  // the icache plus AXI slave surrounding it
  modport slave (
    output in_paddr, in_psel, in_arlen, in_arsize,
    input  out_rvalid, out_rlast, out_rdata, out_rerr,
    input  m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst,
    output m_arready,
    output m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
    input  m_rready
  );

endinterface

// File: rtl/ysyx_23060025_icache_axi_rd.sv
// rtl/ysyx_23060025_icache_axi_rd.sv - single-outstanding AXI4 burst read master feeding icache line refills
module ysyx_23060025_icache_axi_rd
  import ysyx_23060025_icache_axi_rd_pkg::*;
#(
  parameter int             ID_W       = 4,
  parameter logic [ID_W-1:0] AXI_ID    = '0,
  parameter int             ADDR_WIDTH = 32,
  parameter int             DATA_WIDTH = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  ysyx_23060025_icache_axi_rd_if.master bus
);

  state_e                r_state;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_rerr;
  logic [7:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]            r_arlen;
  logic [2:0]            r_arsize;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_beat_err;
  logic [DATA_WIDTH-1:0] w_rdata;

  // r_rready is only high in DATA, so foreign-ID beats are drained but never forwarded
  assign w_accept   = r_rready & bus.m_rvalid & (bus.m_rid == AXI_ID);
  // burst termination follows our own beat count; the slave's RLAST is only cross-checked
  assign w_last     = (r_cnt == r_arlen);
  assign w_beat_err = (bus.m_rresp != AXI_RESP_OKAY) | (bus.m_rlast != w_last);
  assign w_rdata    = w_accept ? bus.m_rdata : '0;

  assign bus.out_rvalid = w_accept;
  assign bus.out_rlast  = w_accept & w_last;
  assign bus.out_rdata  = w_rdata;
  assign bus.out_rerr   = r_rerr;

  assign bus.m_arvalid  = r_arvalid;
  assign bus.m_araddr   = r_araddr;
  assign bus.m_arid     = AXI_ID;
  assign bus.m_arlen    = r_arlen;
  assign bus.m_arsize   = r_arsize;
  assign bus.m_arburst  = AXI_BURST_INCR;
  assign bus.m_rready   = r_rready;

  // request FSM: latch refill, issue one AR, count R beats, then wait for psel to drop
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_rerr    <= 1'b0;
      r_cnt     <= 8'd0;
      r_araddr  <= '0;
      r_arlen   <= 8'd0;
      r_arsize  <= AXI_ADDR_SIZE_4;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_psel) begin
            r_araddr  <= bus.in_paddr;
            r_arlen   <= bus.in_arlen;
            r_arsize  <= bus.in_arsize;
            r_rerr    <= 1'b0;
            r_cnt     <= 8'd0;
            r_arvalid <= 1'b1;
            r_state   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (bus.m_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            r_cnt <= r_cnt + 8'd1;
            if (w_beat_err) begin
              r_rerr <= 1'b1;
            end
            if (w_last) begin
              r_rready <= 1'b0;
              r_state  <= ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          // icache's psel is registered and lingers a cycle past rlast
          if (!bus.in_psel) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
